// File: rtl/hs_1007_cell.sv
// hs_1007_cell: one combinational half-subtractor lane (a - b).
// Produces the difference bit and the borrow-out for a single bit position.
module hs_1007_cell (
  input  logic a,
  input  logic b,
  output logic d,
  output logic br
);

  // The difference is set when the bits differ.
  // A borrow is needed only when subtracting 1 from 0.
  always_comb begin
    d  = a ^ b;
    br = ~a & b;
  end

endmodule

// File: rtl/hs_1007.sv
// hs_1007: registered half subtractor with WIDTH independent lanes.
// Each lane computes its result separately; borrows never ripple between lanes.
// Results appear one clock after the operands are sampled with in_valid high.
module hs_1007 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] br,
  output logic             br_any,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] LANES_CLEAR = '0;

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_borrow;

  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] r_borrow;
  logic             r_borrowAny;
  logic             r_outValid;

  for (genvar gLane = 0; gLane < WIDTH; gLane++) begin : gCell
    hs_1007_cell uCell (
      .a  (a[gLane]),
      .b  (b[gLane]),
      .d  (w_diff[gLane]),
      .br (w_borrow[gLane])
    );
  end

  // Capture the lane results only when operands are qualified, so unqualified
  // (possibly unknown) inputs cannot disturb the held result; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff      <= LANES_CLEAR;
      r_borrow    <= LANES_CLEAR;
      r_borrowAny <= 1'b0;
      r_outValid  <= 1'b0;
    end else begin
      r_outValid <= in_valid;
      if (in_valid) begin
        r_diff      <= w_diff;
        r_borrow    <= w_borrow;
        r_borrowAny <= |w_borrow;
      end
    end
  end

  assign d         = r_diff;
  assign br        = r_borrow;
  assign br_any    = r_borrowAny;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_hs_1007.sv
// tb_hs_1007: directed bench for hs_1007 with a scalar and a 4-lane instance.
// Both instances share reset, valid and (bit 0 of) the operands.
module tb_hs_1007;

  logic       clock = 1'b0;
  logic       rst;
  logic       inValid;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       a1;
  logic       b1;

  logic       d1;
  logic       br1;
  logic       brAny1;
  logic       outValid1;
  logic [3:0] d4;
  logic [3:0] br4;
  logic       brAny4;
  logic       outValid4;

  int errors = 0;
  int checks = 0;

  // 10 ns clock period.
  always #5 clock = ~clock;

  hs_1007 #(.WIDTH(1)) dut1 (
    .clk       (clock),
    .rst       (rst),
    .in_valid  (inValid),
    .a         (a1),
    .b         (b1),
    .d         (d1),
    .br        (br1),
    .br_any    (brAny1),
    .out_valid (outValid1)
  );

  hs_1007 #(.WIDTH(4)) dut4 (
    .clk       (clock),
    .rst       (rst),
    .in_valid  (inValid),
    .a         (a4),
    .b         (b4),
    .d         (d4),
    .br        (br4),
    .br_any    (brAny4),
    .out_valid (outValid4)
  );

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive inputs on the falling edge, then return 1 ns after the next rising edge.
  task automatic applyStimulus(input logic rstV, input logic validV,
                               input logic [3:0] aV, input logic [3:0] bV);
    @(negedge clock);
    rst     = rstV;
    inValid = validV;
    a4      = aV;
    b4      = bV;
    a1      = aV[0];
    b1      = bV[0];
    @(posedge clock);
    #1;
  endtask

  // Expected-value check for the scalar instance.
  task automatic checkScalar(input string tag, input logic expD, input logic expBr,
                             input logic expValid);
    checkOutput({tag, ".d"},      64'(d1),        64'(expD));
    checkOutput({tag, ".br"},     64'(br1),       64'(expBr));
    checkOutput({tag, ".brAny"},  64'(brAny1),    64'(expBr));
    checkOutput({tag, ".valid"},  64'(outValid1), 64'(expValid));
  endtask

  // Directed scenarios with hand-computed results.
  initial begin
    logic [3:0] vecA [4];
    logic [3:0] vecB [4];
    logic       expD [4];
    logic       expBr [4];
    vecA  = '{4'd0, 4'd0, 4'd1, 4'd1};
    vecB  = '{4'd0, 4'd1, 4'd0, 4'd1};
    expD  = '{1'b0, 1'b1, 1'b1, 1'b0};
    expBr = '{1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; inValid = 1'b1; a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1;

    // Reset held with valid operands present: outputs stay cleared.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 4'hF, 4'hF);
      checkScalar("reset", 1'b0, 1'b0, 1'b0);
      checkOutput("reset.d4", 64'(d4), 64'h0);
      checkOutput("reset.valid4", 64'(outValid4), 64'h0);
    end

    // Scalar truth table, back to back.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, vecA[i], vecB[i]);
      checkScalar($sformatf("truth%0d", i), expD[i], expBr[i], 1'b1);
    end

    // One valid (0,1), then hold with toggling and unknown operands.
    applyStimulus(1'b0, 1'b1, 4'h0, 4'h1);
    checkScalar("holdLoad", 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h1, 4'h0);
    checkScalar("hold0", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h1, 4'h1);
    checkScalar("hold1", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
    checkScalar("holdX", 1'b1, 1'b1, 1'b0);

    // Reset coincident with a valid operand pair discards it.
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h1);
    checkScalar("rstMid", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h1);
    checkScalar("postRst", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h1, 4'h0);
    checkScalar("firstAfterRst", 1'b1, 1'b0, 1'b1);

    // Four independent lanes: no borrow ripple.
    applyStimulus(1'b0, 1'b1, 4'b0101, 4'b0011);
    checkOutput("w4a.d",     64'(d4),        64'(4'b0110));
    checkOutput("w4a.br",    64'(br4),       64'(4'b0010));
    checkOutput("w4a.brAny", 64'(brAny4),    64'h1);
    checkOutput("w4a.valid", 64'(outValid4), 64'h1);
    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
    checkOutput("w4b.d",     64'(d4),        64'(4'b1111));
    checkOutput("w4b.br",    64'(br4),       64'(4'b0000));
    checkOutput("w4b.brAny", 64'(brAny4),    64'h0);
    checkOutput("w4b.valid", 64'(outValid4), 64'h1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b1111);
    checkOutput("w4c.d",     64'(d4),        64'(4'b1111));
    checkOutput("w4c.br",    64'(br4),       64'(4'b1111));
    checkOutput("w4c.brAny", 64'(brAny4),    64'h1);
    applyStimulus(1'b0, 1'b0, 4'b1010, 4'b0101);
    checkOutput("w4hold.d",     64'(d4),        64'(4'b1111));
    checkOutput("w4hold.br",    64'(br4),       64'(4'b1111));
    checkOutput("w4hold.valid", 64'(outValid4), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
